// File: rtl/bcomp_pkg.sv
// Shared definitions for the bcomp controller and its capture stages.
package bcomp_pkg;

  localparam int unsigned UOP_W     = 39;
  localparam int unsigned GAP_W_DEF = 8;

  typedef logic [UOP_W-1:0] uop_t;

  typedef struct packed {
    uop_t                 uop;
    logic [GAP_W_DEF-1:0] gap;
  } uop_entry_t;

endpackage

// File: rtl/bcomp_fifo_core.sv
// Generic first-word-fall-through FIFO: storage, wrapping pointers, tracked count.
module bcomp_fifo_core #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned W     = 47
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             wdata,
  output logic [W-1:0]             rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count_q;
  logic          wr;
  logic          rd;

  // Pop only when data exists; push when space exists or a pop frees a slot this cycle.
  assign rd = pop && (count_q != '0);
  assign wr = push && ((count_q != DEPTH[AW:0]) || rd);

  always_ff @(posedge clk) begin
    if (wr) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (wr) wr_ptr <= wr_ptr + 1'b1;
      if (rd) rd_ptr <= rd_ptr + 1'b1;
      case ({wr, rd})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign rdata = mem[rd_ptr];
  assign count = count_q;
  assign full  = (count_q == DEPTH[AW:0]);
  assign empty = (count_q == '0);

endmodule

// File: rtl/bcomp_uop_fifo.sv
// Captures non-zero bcomp micro-op vectors with an idle-gap tag into a FWFT queue.
module bcomp_uop_fifo
  import bcomp_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned GAP_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     uop_en,
  input  logic [UOP_W-1:0]         uop_in,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [UOP_W-1:0]         out_uop,
  output logic [GAP_W-1:0]         out_gap,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic                     overflow,
  input  logic                     clr_ovf
);

  localparam int unsigned EW = UOP_W + GAP_W;

  logic [GAP_W-1:0] gap_q;
  logic             capture;
  logic             idle;
  logic             pop_ok;
  logic             accepted;
  logic             dropped;
  logic [EW-1:0]    wdata;
  logic [EW-1:0]    rdata;

  assign capture  = uop_en && (uop_in != '0);
  assign idle     = uop_en && (uop_in == '0);
  assign pop_ok   = out_valid && out_ready;
  assign accepted = capture && (!full || pop_ok);
  assign dropped  = capture && !accepted;
  assign wdata    = {uop_in, gap_q};

  bcomp_fifo_core #(
    .DEPTH (DEPTH),
    .W     (EW)
  ) u_core (
    .clk   (clk),
    .rst   (rst),
    .push  (accepted),
    .pop   (pop_ok),
    .wdata (wdata),
    .rdata (rdata),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  // A dropped capture ages the gap exactly like an idle cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gap_q    <= '0;
      overflow <= 1'b0;
    end else begin
      if (accepted)
        gap_q <= '0;
      else if ((idle || dropped) && (gap_q != '1))
        gap_q <= gap_q + 1'b1;

      if (dropped)
        overflow <= 1'b1;
      else if (clr_ovf)
        overflow <= 1'b0;
    end
  end

  assign out_valid = !empty;
  assign out_uop   = rdata[EW-1:GAP_W];
  assign out_gap   = rdata[GAP_W-1:0];

endmodule

// File: tb/tb_bcomp_uop_fifo.sv
// Directed self-checking bench for bcomp_uop_fifo (DEPTH=8, GAP_W=8).
module tb_bcomp_uop_fifo;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        uop_en = 1'b0;
  logic [38:0] uop_in = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [38:0] out_uop;
  logic [7:0]  out_gap;
  logic [3:0]  count;
  logic        full;
  logic        empty;
  logic        overflow;
  logic        clr_ovf = 1'b0;

  int unsigned checks = 0;
  int unsigned failures = 0;
  logic [38:0] exp_q[$];

  bcomp_uop_fifo #(
    .DEPTH (8),
    .GAP_W (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .uop_en    (uop_en),
    .uop_in    (uop_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_uop   (out_uop),
    .out_gap   (out_gap),
    .count     (count),
    .full      (full),
    .empty     (empty),
    .overflow  (overflow),
    .clr_ovf   (clr_ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cap(input logic [38:0] v);
    uop_en = 1'b1;
    uop_in = v;
    tick();
    uop_en = 1'b0;
    uop_in = '0;
  endtask

  task automatic pop_check(input string tag, input logic [38:0] v);
    check({tag, "_valid"}, 64'(out_valid), 64'd1);
    check({tag, "_uop"}, 64'(out_uop), 64'(v));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    // Reset then idle
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    repeat (10) tick();
    check("rst_empty", 64'(empty), 64'd1);
    check("rst_count", 64'(count), 64'd0);
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_ovf", 64'(overflow), 64'd0);
    check("rst_full", 64'(full), 64'd0);

    // Pop from empty has no effect
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("empty_pop_count", 64'(count), 64'd0);

    // Gap tagging: three idle cycles then two back-to-back captures
    uop_en = 1'b1;
    uop_in = '0;
    repeat (3) tick();
    uop_in = 39'h4;
    tick();
    check("gap_count1", 64'(count), 64'd1);
    check("gap_head_uop", 64'(out_uop), 64'h4);
    check("gap_head_gap", 64'(out_gap), 64'd3);
    uop_in = 39'h1;
    tick();
    uop_en = 1'b0;
    uop_in = '0;
    check("gap_count2", 64'(count), 64'd2);
    pop_check("gap_pop0", 39'h4);
    check("gap_second_gap", 64'(out_gap), 64'd0);
    pop_check("gap_pop1", 39'h1);
    check("gap_drained", 64'(empty), 64'd1);

    // Fill to full, one dropped capture, then a drop coinciding with clr_ovf
    for (int unsigned i = 0; i < 9; i++) cap(39'h100 + 39'(i));
    check("fill_count", 64'(count), 64'd8);
    check("fill_full", 64'(full), 64'd1);
    check("fill_ovf", 64'(overflow), 64'd1);
    clr_ovf = 1'b1;
    cap(39'h109);
    clr_ovf = 1'b0;
    check("ovf_set_wins", 64'(overflow), 64'd1);
    check("ovf_drop_count", 64'(count), 64'd8);
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    check("ovf_cleared", 64'(overflow), 64'd0);
    for (int unsigned i = 0; i < 8; i++) pop_check($sformatf("fill_pop%0d", i), 39'h100 + 39'(i));
    check("fill_drained", 64'(empty), 64'd1);

    // Full with simultaneous pop; two dropped captures left gap at 2
    for (int unsigned i = 0; i < 8; i++) cap(39'h200 + 39'(i));
    check("refill_full", 64'(full), 64'd1);
    check("refill_head_gap", 64'(out_gap), 64'd2);
    out_ready = 1'b1;
    cap(39'h2ff);
    out_ready = 1'b0;
    check("fullpop_count", 64'(count), 64'd8);
    check("fullpop_ovf", 64'(overflow), 64'd0);
    check("fullpop_full", 64'(full), 64'd1);
    for (int unsigned i = 1; i < 8; i++) exp_q.push_back(39'h200 + 39'(i));
    exp_q.push_back(39'h2ff);
    for (int unsigned i = 0; i < 8; i++) begin
      if (i == 7) check("fullpop_last_gap", 64'(out_gap), 64'd0);
      pop_check($sformatf("fullpop_pop%0d", i), exp_q.pop_front());
    end
    check("fullpop_drained", 64'(count), 64'd0);

    // Gap saturation
    uop_en = 1'b1;
    uop_in = '0;
    repeat (300) tick();
    cap(39'h70_0000_0000);
    check("sat_gap", 64'(out_gap), 64'd255);
    pop_check("sat_pop", 39'h70_0000_0000);

    // Async reset mid-stream with 5 entries and a non-zero pending gap
    for (int unsigned i = 0; i < 5; i++) cap(39'h300 + 39'(i));
    uop_en = 1'b1;
    uop_in = '0;
    repeat (2) tick();
    uop_en = 1'b0;
    check("pre_rst_count", 64'(count), 64'd5);
    #2;
    rst = 1'b1;
    #1;
    check("arst_count", 64'(count), 64'd0);
    check("arst_valid", 64'(out_valid), 64'd0);
    check("arst_empty", 64'(empty), 64'd1);
    #1;
    rst = 1'b0;
    tick();
    cap(39'h55);
    check("post_rst_count", 64'(count), 64'd1);
    check("post_rst_uop", 64'(out_uop), 64'h55);
    check("post_rst_gap", 64'(out_gap), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bcomp_uop_fifo.md
# bcomp_uop_fifo

Downstream capture stage for the `bcomp` controller. It samples the controller's 39-bit micro-operation vector (y1..y39) every qualified cycle and queues each non-zero vector with an idle-gap count. The queue is a first-word-fall-through FIFO drained by a valid/ready consumer, such as a datapath executor or a trace/compare harness used for lock evaluation.

## Interface
Parameters:
- `DEPTH`, 8: number of FIFO entries; power of 2, at least 2.
- `GAP_W`, 8: width of the idle-gap counter stored with each entry.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `uop_en`  in  1  sample qualifier; high means `uop_in` is valid this cycle.
- `uop_in`  in  39  micro-op vector; bit 0 = y1 … bit 38 = y39.
- `out_valid`  out  1  head entry present.
- `out_ready`  in  1  consumer accepts the head entry.
- `out_uop`  out  39  head entry micro-op vector.
- `out_gap`  out  GAP_W  head entry idle-gap count.
- `count`  out  $clog2(DEPTH)+1  number of occupied entries.
- `full`  out  1  `count == DEPTH`.
- `empty`  out  1  `count == 0`.
- `overflow`  out  1  sticky flag: a capture was dropped.
- `clr_ovf`  in  1  clears `overflow`.

## Operation
- Capture event: `uop_en && uop_in != 0`.
- Idle cycle: `uop_en && uop_in == 0`. Cycles with `uop_en` low change nothing.
- Gap counter `gap_q`:
  - An idle cycle increments it, saturating at all-ones.
  - An accepted capture pushes {`uop_in`, `gap_q`} and sets `gap_q` to 0.
- Pop: `out_valid && out_ready`. Popping from an empty FIFO has no effect.
- Push when full:
  - If a pop occurs in the same cycle, the push is accepted and `count` is unchanged.
  - Otherwise the capture is dropped: `overflow` is set, and `gap_q` increments (saturating) as if the cycle were idle.
- Simultaneous push and pop when not full: both take effect and `count` is unchanged.
- `overflow`: a set in the same cycle as `clr_ovf` wins; otherwise `clr_ovf` clears it.
- Read/write pointers are `$clog2(DEPTH)` bits wide and wrap naturally modulo `DEPTH`. `count` is tracked separately; full/empty are derived from `count`, never from pointer equality.
- `out_uop` and `out_gap` are driven from the head entry. When `out_valid` is low their values are don't-care, but the head storage is not cleared.

## Timing
- Reset values: `count`=0, `empty`=1, `full`=0, `out_valid`=0, `overflow`=0, `gap_q`=0, pointers=0. Storage contents are not reset.
- Reset mid-operation discards all entries immediately (asynchronous). The first capture after reset carries gap 0.
- Capture at edge N gives `out_valid`=1 with that data from just after edge N: one-cycle latency, no extra output register.
- A pop at edge N exposes the next entry after edge N.
- Sustained throughput is one push and one pop per cycle.
- `full`, `empty` and `count` are registered-state derived and update at the same edge as the push/pop.
- `out_valid` must not depend combinationally on `out_ready`.

## Structure
- Shared package `bcomp_pkg`:
  - `UOP_W = 39`
  - `typedef logic [UOP_W-1:0] uop_t`
  - entry struct `{uop_t uop; logic [GAP_W-1:0] gap;}`, defined in the package with the default `GAP_W`
- One sub-module, `bcomp_fifo_core`: storage array, pointers, count and full/empty for a generic-width entry.
- The top level holds the capture/idle qualification, the gap counter and the overflow logic.

## Test plan
- Reset then idle: `rst` pulse, `uop_en`=0 for 10 cycles -> `empty`=1, `count`=0, `out_valid`=0, `overflow`=0.
- Gap tagging: idle, idle, idle, then `uop_in`=39'h4 with `uop_en` held high -> head is `out_uop`=39'h4, `out_gap`=3. The next back-to-back capture 39'h1 has gap 0.
- Fill/overflow (`DEPTH`=8, `out_ready`=0): 9 captures -> `count`=8, `full`=1, `overflow`=1, entries 1..8 intact. Then `clr_ovf` -> `overflow`=0.
- Full with simultaneous pop: FIFO full, capture with `out_ready`=1 -> `count` stays 8, no overflow, new entry appears last after 8 pops.
- Gap saturation (`GAP_W`=8): 300 idle cycles then a capture -> `out_gap`=255.
- Async reset mid-stream: reset asserted between edges with 5 entries queued -> `count`=0 and `out_valid`=0 before the next edge; the next capture has gap 0.
